// File: rtl/ecc_apb_stimulus.sv
// APB master that programs one ECC test vector, waits for the DUT's done edge, and returns the result.
// Latency: 8 bus cycles + WAIT_DONE cycles + 1 RESP cycle; result is held until res_ready.
module ecc_apb_stimulus #(
  parameter int DATA_WIDTH      = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       vec_valid,
  output logic                       vec_ready,
  input  logic [1:0]                 vec_ctrl,
  input  logic [DATA_WIDTH-1:0]      vec_data,
  input  logic [1:0]                 vec_width,
  input  logic [DATA_WIDTH-1:0]      vec_noise,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic [AMBA_WORD-1:0]       PWDATA,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  input  logic                       operation_done,
  input  logic [DATA_WIDTH-1:0]      data_out,
  input  logic [1:0]                 num_of_errors,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [DATA_WIDTH-1:0]      res_data,
  output logic [1:0]                 res_num_errors,
  output logic                       res_timeout,
  output logic [7:0]                 res_latency,
  output logic [15:0]                txn_count
);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WAIT_DONE, RESP} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES);

  state_t                state, state_n;
  logic [1:0]            idx, idx_n;
  logic [7:0]            cnt, cnt_n, cnt_inc;
  logic                  done_q, done_rise;
  logic                  accept, capture, cap_timeout, bus_n;
  logic [1:0]            lat_ctrl, lat_width, src_ctrl, src_width;
  logic [DATA_WIDTH-1:0] lat_data, lat_noise, src_data, src_noise;
  logic [3:0]            addr_n;
  logic [AMBA_WORD-1:0]  word_n;

  assign accept    = (state == IDLE) && vec_valid && vec_ready;
  assign done_rise = operation_done && !done_q;
  assign cnt_inc   = cnt + 8'd1;

  // The first SETUP is registered on the accept edge, before the fields are latched.
  assign src_ctrl  = accept ? vec_ctrl  : lat_ctrl;
  assign src_data  = accept ? vec_data  : lat_data;
  assign src_width = accept ? vec_width : lat_width;
  assign src_noise = accept ? vec_noise : lat_noise;

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    cnt_n       = cnt;
    capture     = 1'b0;
    cap_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = SETUP;
          idx_n   = 2'd0;
        end
      end
      SETUP: state_n = ACCESS;
      ACCESS: begin
        if (idx != 2'd3) begin
          state_n = SETUP;
          idx_n   = idx + 2'd1;
        end else begin
          state_n = WAIT_DONE;
          cnt_n   = 8'd0;
        end
      end
      WAIT_DONE: begin
        cnt_n = cnt_inc;
        if (done_rise) begin
          capture = 1'b1;
          state_n = RESP;
        end else if (cnt_inc == TIMEOUT_LAST) begin
          capture     = 1'b1;
          cap_timeout = 1'b1;
          state_n     = RESP;
        end
      end
      RESP: begin
        if (res_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Register order DATA_IN, CODEWORD_WIDTH, NOISE, CTRL so CTRL starts the operation last.
  always_comb begin
    addr_n = 4'h0;
    word_n = '0;
    case (idx_n)
      2'd0: begin addr_n = 4'h4; word_n = AMBA_WORD'(src_data);  end
      2'd1: begin addr_n = 4'h8; word_n = AMBA_WORD'(src_width); end
      2'd2: begin addr_n = 4'hC; word_n = AMBA_WORD'(src_noise); end
      default: begin addr_n = 4'h0; word_n = AMBA_WORD'(src_ctrl); end
    endcase
  end

  assign bus_n = (state_n == SETUP) || (state_n == ACCESS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      idx    <= 2'd0;
      cnt    <= 8'd0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      cnt    <= cnt_n;
      done_q <= operation_done;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_ctrl       <= 2'd0;
      lat_data       <= '0;
      lat_width      <= 2'd0;
      lat_noise      <= '0;
      PSEL           <= 1'b0;
      PENABLE        <= 1'b0;
      PWRITE         <= 1'b0;
      PADDR          <= '0;
      PWDATA         <= '0;
      vec_ready      <= 1'b1;
      res_valid      <= 1'b0;
      res_data       <= '0;
      res_num_errors <= 2'd0;
      res_timeout    <= 1'b0;
      res_latency    <= 8'd0;
      txn_count      <= 16'd0;
    end else begin
      if (accept) begin
        lat_ctrl  <= vec_ctrl;
        lat_data  <= vec_data;
        lat_width <= vec_width;
        lat_noise <= vec_noise;
      end
      PSEL      <= bus_n;
      PENABLE   <= (state_n == ACCESS);
      PWRITE    <= bus_n;
      PADDR     <= bus_n ? AMBA_ADDR_WIDTH'(addr_n) : '0;
      PWDATA    <= bus_n ? word_n : '0;
      vec_ready <= (state_n == IDLE);
      res_valid <= (state_n == RESP);
      if (capture) begin
        res_data       <= data_out;
        res_num_errors <= num_of_errors;
        res_timeout    <= cap_timeout;
        res_latency    <= cnt_inc;
      end
      if (state == RESP && res_ready) txn_count <= txn_count + 16'd1;
    end
  end

endmodule

// File: doc/ecc_apb_stimulus.md
# ecc_apb_stimulus

Upstream APB master for the ECC encoder/decoder. It accepts one test vector per handshake and programs the DUT register file with four zero-wait-state APB writes, CTRL last. It then waits for `operation_done` and returns the DUT result, with latency and timeout status, on a result handshake. This is the stage that feeds the DUT and the Checker's APB/DUT monitor interface.

## Interface
- `DATA_WIDTH`, 32, width of data/noise words
- `AMBA_ADDR_WIDTH`, 20, PADDR width
- `AMBA_WORD`, 32, PWDATA width
- `TIMEOUT_CYCLES`, 16, max WAIT_DONE cycles before timeout (≥2, ≤255)

Ports:
- `clk` in 1 — single clock, all logic on rising edge
- `rst` in 1 — asynchronous, active-low reset
- `vec_valid` in 1 — test vector offered
- `vec_ready` out 1 — vector accepted when `vec_valid && vec_ready`
- `vec_ctrl` in 2 — operation: 00 encode, 01 decode, 10 full
- `vec_data` in DATA_WIDTH — DATA_IN value
- `vec_width` in 2 — CODEWORD_WIDTH value
- `vec_noise` in DATA_WIDTH — NOISE value
- `PADDR` out AMBA_ADDR_WIDTH — APB address
- `PWDATA` out AMBA_WORD — APB write data
- `PSEL`, `PENABLE`, `PWRITE` out 1 each — APB control
- `operation_done` in 1 — from DUT
- `data_out` in DATA_WIDTH — from DUT
- `num_of_errors` in 2 — from DUT
- `res_valid` out 1 — result available
- `res_ready` in 1 — result consumed when `res_valid && res_ready`
- `res_data` out DATA_WIDTH — captured `data_out`
- `res_num_errors` out 2 — captured `num_of_errors`
- `res_timeout` out 1 — 1 = no done seen within TIMEOUT_CYCLES
- `res_latency` out 8 — WAIT_DONE cycles until capture
- `txn_count` out 16 — completed result handshakes, wraps FFFF→0000

## Operation
- Register map (PADDR[3:0]; upper bits 0): CTRL 0x0, DATA_IN 0x4, CODEWORD_WIDTH 0x8, NOISE 0xC.
- Write order is fixed: DATA_IN, CODEWORD_WIDTH, NOISE, CTRL. Writing CTRL starts the DUT operation.
- PWDATA is the zero-extended vector field. Vector fields are latched on acceptance.
- FSM states: IDLE, SETUP, ACCESS, WAIT_DONE, RESP. A 2-bit index selects the register.
  - IDLE: `vec_ready`=1. On accept → SETUP, index=0.
  - SETUP: PSEL=1, PENABLE=0, PWRITE=1. → ACCESS.
  - ACCESS: PSEL=1, PENABLE=1, PWRITE=1. If index<3 → SETUP with index+1; else → WAIT_DONE with wait counter=0.
  - WAIT_DONE: counter increments each cycle. Capture on the rising edge of `operation_done` (`operation_done && !done_q`, where `done_q` is registered every cycle in all states). On capture: latch data, errors, latency=counter+1, timeout=0 → RESP. If counter+1==TIMEOUT_CYCLES with no edge: latch current data/errors, latency=TIMEOUT_CYCLES, timeout=1 → RESP.
  - RESP: `res_valid`=1, result fields held stable. On `res_ready` → IDLE and `txn_count`+1.
- Outside SETUP/ACCESS: PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0.
- All outputs are registered.

## Timing
- Reset (async assert; deassert sampled on clk): state IDLE. All outputs 0 except `vec_ready`=1. `txn_count`=0, `done_q`=0.
- Reset mid-operation aborts immediately. APB goes idle in the same reset assertion, with no partial ACCESS.
- Accept at edge E0 → SETUP visible E0..E1. CTRL ACCESS occupies E7..E8. First WAIT_DONE cycle is E8..E9.
- APB writes are back-to-back: exactly 8 bus cycles, no idle gaps, PADDR/PWDATA stable across each SETUP/ACCESS pair.
- A done level already high when entering WAIT_DONE (stale) is not captured. Only a new rising edge counts.
- `vec_ready`=0 in RESP even if `res_ready`=1. The next vector is accepted no earlier than the following IDLE cycle.
- Minimum vector-to-vector period: 8 + latency + 1 (RESP) + 1 (IDLE) cycles.

## Test plan
- Reset then vector ctrl=00, data=0x0000_00A5, width=0, noise=0 → APB sequence 0x4/0xA5, 0x8/0, 0xC/0, 0x0/0, 8 cycles, PENABLE alternating 0,1.
- DUT model asserts done on the 3rd WAIT_DONE cycle with data_out=0x1234, errors=01 → `res_valid`, res_data=0x1234, res_num_errors=01, res_latency=3, res_timeout=0.
- Done never asserted → RESP after 16 WAIT_DONE cycles, res_timeout=1, res_latency=16.
- Done held high from the previous op into WAIT_DONE, drops, rises on cycle 4 → res_latency=4; no early capture.
- `res_ready` held low 5 cycles, `vec_valid` high → results stable, `vec_ready`=0; `txn_count` increments once on release.
- Reset asserted during the NOISE ACCESS → PSEL/PENABLE=0 immediately, `txn_count`=0; next vector restarts from DATA_IN.
